vga_sync: RTL
=============

# vga_sync

Timing generator driving the display side of the clock/date/timer screen. It divides the system clock down to the pixel rate and runs horizontal and vertical scan counters for 640x480 at 60 Hz. It produces `pixel_x`, `pixel_y` and `video_on`, which the figure and text generators consume, plus the active-low `hsync`/`vsync` for the VGA connector. An optional frame counter paces blinking elements such as the alarm "ring" box.

## Interface
- `TICK_DIV`, 4: system clocks per pixel; 100 MHz gives a 25 MHz pixel rate. Must be ≥2.
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_RETRACE`, 96: hsync pulse width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_DISPLAY`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_RETRACE`, 2: vsync pulse width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `reset`  in  1  synchronous, active-low reset. Sampled on the rising edge of `clk`.
- `p_tick`  out  1  pixel enable. High for one `clk` every `TICK_DIV` cycles.
- `pixel_x`  out  10  horizontal counter, 0..H_TOTAL-1.
- `pixel_y`  out  10  vertical counter, 0..V_TOTAL-1.
- `video_on`  out  1  high inside the 640x480 visible region.
- `hsync`  out  1  horizontal sync, active-low.
- `vsync`  out  1  vertical sync, active-low.
- `frame_start`  out  1  one-`clk` pulse at the start of each frame.
- `frame_cnt`  out  8  frames elapsed, modulo 256. Only present with `VGA_SYNC_FRAME_CNT_EN`.

## Operation
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_RETRACE+H_BACK = 800.
  - V_TOTAL = V_DISPLAY+V_FRONT+V_RETRACE+V_BACK = 525.
- Tick divider:
  - `tick_cnt` counts 0..TICK_DIV-1 and wraps to 0.
  - `p_tick` = (`tick_cnt` == TICK_DIV-1).
- Horizontal counter `h`:
  - Advances only on edges where `p_tick`=1.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter `v`:
  - Advances only on edges where `p_tick`=1 and `h`==H_TOTAL-1.
  - At V_TOTAL-1 it wraps to 0.
- `pixel_x`=`h` and `pixel_y`=`v`, taken directly from the registers.
- `video_on` = (`h` < H_DISPLAY) && (`v` < V_DISPLAY), decoded combinationally from the registered counters.
- `hsync` and `vsync` are registered.
  - Each is computed from the next-state counter values, so it is cycle-aligned with `pixel_x`/`pixel_y`.
  - `hsync`=0 exactly when `h` ∈ [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_RETRACE-1] = [656,751].
  - `vsync`=0 exactly when `v` ∈ [490,491].
- `frame_start` = `p_tick` && (`h`==H_TOTAL-1) && (`v`==V_TOTAL-1). It marks the edge on which the counters return to (0,0).
- Counter widths are fixed at 10 bits. Any parameter set with H_TOTAL or V_TOTAL > 1024 is illegal.

## Timing
- Reset, taking effect on the first `clk` edge with `reset`=0:
  - `tick_cnt`=0, `h`=0, `v`=0.
  - `hsync`=1, `vsync`=1.
  - `p_tick`=0, `frame_start`=0, `video_on`=1.
  - `frame_cnt`=0.
- Reset asserted mid-line or mid-frame overrides everything in the same edge. No partial state survives.
- After `reset` is released, `p_tick` first rises TICK_DIV-1 cycles later. `pixel_x` becomes 1 on the following edge.
- Each pixel value is held for exactly TICK_DIV `clk` cycles.
  - A line is 800·TICK_DIV cycles (3200 at default).
  - A frame is 525 lines (1,680,000 cycles at default).
- When a line wrap and a frame wrap fall on the same edge, `h` and `v` both go to 0 together, and `vsync`/`hsync` update consistently on that edge.
- Output latency from `pixel_x`/`pixel_y` to `hsync`/`vsync`/`video_on` is 0. Downstream RGB logic that registers its output adds one `clk` and must compensate on its own side.

## Configuration
- `VGA_SYNC_FRAME_CNT_EN` defined:
  - The `frame_cnt` port exists.
  - It increments by 1 on every `frame_start` and wraps 255→0.
  - It resets to 0.
- `VGA_SYNC_FRAME_CNT_EN` undefined:
  - The port and its register are absent.
  - All other behaviour is identical.

## Test plan
- Release reset, then count cycles: `p_tick` is high at cycles 3, 7, 11…, and `pixel_x` goes 0→1 after the 4th `clk`.
- Run a full line: `pixel_x` reaches 799 and wraps to 0; `pixel_y` goes 0→1 on the same edge; `hsync` is low for exactly 96·4 = 384 cycles, starting when `pixel_x`=656.
- Run a full frame: `vsync` is low for exactly lines 490–491 (6400 cycles); `frame_start` pulses once per 1,680,000 cycles, on the edge where (799,524)→(0,0).
- Check `video_on` at the boundaries: 1 at (639,479); 0 at (640,0), (0,480) and (799,524).
- Assert reset at (300,200) for 1 cycle: the next edge shows `pixel_x`=0, `pixel_y`=0, `hsync`=`vsync`=1, `p_tick`=0.
- With `VGA_SYNC_FRAME_CNT_EN` defined, run 257 frames: `frame_cnt` reads 1 after the wrap (255→0→1); with the macro undefined, the build elaborates without the port.

Source files
------------

// File: rtl/vga_sync.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync
//  Purpose  : VGA timing generator. Divides clk down to the pixel rate and
//             runs horizontal/vertical scan counters (640x480 @ 60 Hz by
//             default). Supplies pixel coordinates, the visible-region flag,
//             active-low sync pulses and a start-of-frame strobe.
//  Ports    : clk          system clock (single domain)
//             reset        synchronous, active-low reset
//             p_tick       pixel enable, one clk every TICK_DIV cycles
//             pixel_x      horizontal position, 0..H_TOTAL-1
//             pixel_y      vertical position, 0..V_TOTAL-1
//             video_on     high inside the visible region
//             hsync        horizontal sync, active-low, registered
//             vsync        vertical sync, active-low, registered
//             frame_start  one-clk pulse on the edge returning to (0,0)
//             frame_cnt    frames elapsed modulo 256
//                          (only with VGA_SYNC_FRAME_CNT_EN defined)
//  Options  : VGA_SYNC_FRAME_CNT_EN - adds the frame_cnt port and register
//  Revision : 1.0 - initial release
// ============================================================================
module vga_sync #(
  parameter int TICK_DIV  = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_RETRACE = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_RETRACE = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;
  localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS     = 10'(H_DISPLAY);
  localparam logic [9:0]    V_VIS     = 10'(V_DISPLAY);
  localparam logic [9:0]    HS_FIRST  = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]    HS_LAST   = 10'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
  localparam logic [9:0]    VS_FIRST  = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]    VS_LAST   = 10'(V_DISPLAY + V_FRONT + V_RETRACE - 1);

  logic [TW-1:0] tick_cnt;
  logic [9:0]    h;
  logic [9:0]    v;
  logic [9:0]    h_next;
  logic [9:0]    v_next;

  assign p_tick      = (tick_cnt == TICK_LAST);
  assign pixel_x     = h;
  assign pixel_y     = v;
  assign video_on    = (h < H_VIS) && (v < V_VIS);
  assign frame_start = p_tick && (h == H_LAST) && (v == V_LAST);

  // Next-state scan position; also feeds the sync registers so the sync
  // outputs line up with pixel_x/pixel_y on the same cycle.
  always_comb begin
    h_next = h;
    v_next = v;
    if (p_tick) begin
      if (h == H_LAST) begin
        h_next = '0;
        v_next = (v == V_LAST) ? '0 : v + 10'd1;
      end else begin
        h_next = h + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt <= '0;
      h        <= '0;
      v        <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
    end else begin
      tick_cnt <= p_tick ? '0 : tick_cnt + TW'(1);
      h        <= h_next;
      v        <= v_next;
      hsync    <= !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
      vsync    <= !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire
